// File: rtl/seg_bcd_driver_if.sv
// seg_bcd_driver_if: value/clear request into the display driver, segment/status back out.
// Ports: value[7:0] binary number, clr blank request, seg1..seg4[6:0] active-low {g..a},
//        busy conversion in progress, done one-cycle pulse on new digits.
interface seg_bcd_driver_if;
    logic [7:0] value;
    logic       clr;
    logic [6:0] seg1;
    logic [6:0] seg2;
    logic [6:0] seg3;
    logic [6:0] seg4;
    logic       busy;
    logic       done;
    modport master (output value, clr, input seg1, seg2, seg3, seg4, busy, done);
    modport slave  (input value, clr, output seg1, seg2, seg3, seg4, busy, done);
endinterface

// File: rtl/seg_bcd_driver.sv
// seg_bcd_driver: sequential double-dabble of an 8-bit value onto four active-low 7-seg displays.
// Ports: clk, rst (async, active-high), bus (slave): value/clr in; seg1 ones, seg2 tens,
//        seg3 hundreds, seg4 sign; busy during SHIFT/UPDATE; done pulse after digits are written.
module seg_bcd_driver #(
    parameter bit SIGNED = 1'b0
) (
    input logic             clk,
    input logic             rst,
    seg_bcd_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;
    state_t      state, state_nx;
    logic [7:0]  bin, last_value, cap_value, mag;
    logic [11:0] bcd, bcd_adj;
    logic [2:0]  cnt;
    logic [3:0]  dig_h, dig_t, dig_o;
    logic [6:0]  seg1, seg2, seg3, seg4;
    logic        pending, cap_sign, sign, neg, start, done_r;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0: seg_code = 7'h40;
            4'd1: seg_code = 7'h79;
            4'd2: seg_code = 7'h24;
            4'd3: seg_code = 7'h30;
            4'd4: seg_code = 7'h19;
            4'd5: seg_code = 7'h12;
            4'd6: seg_code = 7'h02;
            4'd7: seg_code = 7'h78;
            4'd8: seg_code = 7'h00;
            4'd9: seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    assign neg   = SIGNED && bus.value[7];
    // -128 negates to 8'h80, which read unsigned is the wanted magnitude 128
    assign mag   = neg ? ~bus.value + 8'd1 : bus.value;
    assign start = pending || (bus.value != last_value);

    for (genvar i = 0; i < 3; i++) begin : g_adj
        assign bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? SHIFT : IDLE;
            SHIFT:   state_nx = (cnt == 3'd7) ? UPDATE : SHIFT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            pending    <= 1'b1;
            last_value <= '0;
            cap_value  <= '0;
            cap_sign   <= 1'b0;
            dig_h      <= '0;
            dig_t      <= '0;
            dig_o      <= '0;
            sign       <= 1'b0;
            done_r     <= 1'b0;
            seg1       <= 7'h7F;
            seg2       <= 7'h7F;
            seg3       <= 7'h7F;
            seg4       <= 7'h7F;
        end else begin
            done_r <= (state == UPDATE);
            case (state)
                IDLE: if (start) begin
                    bin       <= mag;
                    bcd       <= '0;
                    cnt       <= '0;
                    pending   <= 1'b0;
                    cap_value <= bus.value;
                    cap_sign  <= neg;
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    cnt        <= cnt + 3'd1;
                end
                default: begin
                    dig_h      <= bcd[11:8];
                    dig_t      <= bcd[7:4];
                    dig_o      <= bcd[3:0];
                    sign       <= cap_sign;
                    last_value <= cap_value;
                end
            endcase
            // leading-zero blanking; the ones digit is always shown
            seg1 <= bus.clr ? 7'h7F : seg_code(dig_o);
            seg2 <= (bus.clr || (dig_h == 4'd0 && dig_t == 4'd0)) ? 7'h7F : seg_code(dig_t);
            seg3 <= (bus.clr || dig_h == 4'd0) ? 7'h7F : seg_code(dig_h);
            seg4 <= (!bus.clr && sign) ? 7'h3F : 7'h7F;
        end
    end

    assign bus.seg1 = seg1;
    assign bus.seg2 = seg2;
    assign bus.seg3 = seg3;
    assign bus.seg4 = seg4;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
endmodule

// File: tb/tb_seg_bcd_driver.sv
// tb_seg_bcd_driver: unsigned and signed instances driven in lockstep, checked against an arithmetic model.
module tb_seg_bcd_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] value = 8'd0;
    logic       clr = 1'b0;
    logic [7:0] shown = 8'd0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [6:0] code [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg_bcd_driver_if ub ();
    seg_bcd_driver_if sb ();

    assign ub.value = value;
    assign ub.clr   = clr;
    assign sb.value = value;
    assign sb.clr   = clr;

    seg_bcd_driver #(.SIGNED(1'b0)) u_uns (.clk(clk), .rst(rst), .bus(ub));
    seg_bcd_driver #(.SIGNED(1'b1)) u_sgn (.clk(clk), .rst(rst), .bus(sb));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] model(input logic [7:0] v, input bit sgn, input bit blank);
        int m;
        bit minus;
        logic [6:0] s1, s2, s3, s4;
        if (blank) return {4{7'h7F}};
        minus = sgn && (v >= 8'd128);
        m  = minus ? 256 - int'(v) : int'(v);
        s1 = code[m % 10];
        s2 = (m < 10)  ? 7'h7F : code[(m / 10) % 10];
        s3 = (m < 100) ? 7'h7F : code[m / 100];
        s4 = minus ? 7'h3F : 7'h7F;
        return {s4, s3, s2, s1};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_segs(input string tag, input logic [7:0] v);
        check({tag, "_uns"}, {4'd0, ub.seg4, ub.seg3, ub.seg2, ub.seg1}, {4'd0, model(v, 1'b0, clr)});
        check({tag, "_sgn"}, {4'd0, sb.seg4, sb.seg3, sb.seg2, sb.seg1}, {4'd0, model(v, 1'b1, clr)});
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!ub.done && k < 40);
        check({tag, "_done"}, {31'd0, ub.done && sb.done}, 32'd1);
    endtask

    task automatic show(input logic [7:0] v, input string tag);
        value = v;
        if (v != shown) begin
            wait_done(tag);
            step();
        end
        shown = v;
        check_segs(tag, v);
    endtask

    initial begin
        int busy_n, done_n;
        // reset state and first conversion out of reset
        step();
        check("rst_segs", {4'd0, ub.seg4, ub.seg3, ub.seg2, ub.seg1}, {4'd0, {4{7'h7F}}});
        check("rst_busy_done", {30'd0, ub.busy, ub.done}, 32'd0);
        rst = 1'b0;
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            busy_n += int'(ub.busy);
            done_n += int'(ub.done);
        end
        check("rel_busy_cycles", busy_n, 9);
        check("rel_done_pulses", done_n, 1);
        check_segs("rel_zero", 8'd0);
        // directed values, both interpretations
        show(8'd255, "v255");
        show(8'd7, "v7");
        show(8'd100, "v100");
        show(8'd10, "v10");
        show(8'h80, "v80");
        show(8'hFF, "vFF");
        show(8'h7F, "v7F");
        show(8'd0, "v0");
        // exact latency 0 -> 42
        value = 8'd42;
        for (int i = 0; i <= 10; i++) begin
            step();
            if (i == 0) check("lat_busy0", {31'd0, ub.busy}, 32'd1);
            if (i == 9) begin
                check("lat_done9", {31'd0, ub.done}, 32'd1);
                check_segs("lat_old9", 8'd0);
            end
        end
        shown = 8'd42;
        check_segs("lat_new10", 8'd42);
        // change during SHIFT: 42 first, then 99
        show(8'd0, "pre_mid");
        value = 8'd42;
        step();
        step();
        step();
        value = 8'd99;
        wait_done("mid_first");
        step();
        check("mid_restart_busy", {31'd0, ub.busy}, 32'd1);
        check_segs("mid_first42", 8'd42);
        wait_done("mid_second");
        step();
        check_segs("mid_second99", 8'd99);
        shown = 8'd99;
        // clr during a conversion of 200
        show(8'd0, "pre_clr");
        value = 8'd200;
        step();
        step();
        step();
        clr = 1'b1;
        step();
        check_segs("clr_blank", 8'd200);
        wait_done("clr_conv");
        step();
        check_segs("clr_still_blank", 8'd200);
        clr = 1'b0;
        step();
        check_segs("clr_release", 8'd200);
        check("clr_no_reconv", {31'd0, ub.busy}, 32'd0);
        shown = 8'd200;
        // async reset mid-SHIFT
        show(8'd0, "pre_rst");
        value = 8'd77;
        step();
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_segs", {4'd0, sb.seg4, sb.seg3, sb.seg2, sb.seg1}, {4'd0, {4{7'h7F}}});
        check("arst_busy", {31'd0, ub.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_done("arst_conv");
        step();
        check_segs("arst_77", 8'd77);
        shown = 8'd77;
        // randomized values
        for (int n = 0; n < 25; n++) show(8'($urandom_range(0, 255)), "rand");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
